// File: rtl/rca3_result_accumulator.sv
// Frame accumulator behind the 3-bit ripple-carry adder: sums FRAME_LEN
// {cout,sum} results and hands the total plus a sticky wrap flag downstream.
module rca3_result_accumulator #(
  parameter int ACC_W     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic               accept;
  logic               clr;
  logic               acc_en;
  logic [ACC_W-1:0]   beat;
  logic [ACC_W:0]     sum_ext;

  // Unsigned add keeping the carry-out as the top bit; the low bits wrap.
  function automatic logic [ACC_W:0] wrap_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign beat    = ACC_W'({in_cout, in_sum});
  assign sum_ext = wrap_add(acc, beat);

  // Handshake outputs come from the state register only, no input feedthrough.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    acc_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_en = 1'b1;
          if (cnt == LAST_BEAT) state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A start coinciding with the handshake opens the next frame directly.
        if (out_ready) begin
          if (start) begin
            clr       = 1'b1;
            state_nxt = ACCUM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (acc_en) begin
      acc <= sum_ext[ACC_W-1:0];
      ovf <= ovf | sum_ext[ACC_W];
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/rca3_result_accumulator.md
Name: rca3_result_accumulator

Overview:
Downstream stage of the 3-bit ripple-carry adder: consumes the adder's 3-bit sum plus carry-out as a 4-bit result (0..14) and accumulates a frame of FRAME_LEN results into an ACC_W-bit total. Input side uses a valid/ready handshake. Output side presents the frame total and a sticky overflow flag under a valid/ready handshake. A three-state FSM (IDLE/ACCUM/HOLD) sequences framing and backpressure.

Parameters:
ACC_W, 8, accumulator width in bits; legal range 4..32.
FRAME_LEN, 4, accepted adder results per frame; legal range 1..15.
CNT_W, 4, beat counter width; must hold FRAME_LEN-1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  single-cycle pulse that begins a frame.
in_valid  input  1  adder result valid.
in_ready  output  1  block accepts a result this cycle.
in_sum  input  3  adder sum[2:0].
in_cout  input  1  adder carry-out.
out_valid  output  1  frame total valid.
out_ready  input  1  consumer accepts total.
out_acc  output  ACC_W  frame total, modulo 2^ACC_W.
out_ovf  output  1  sticky: accumulator wrapped at least once this frame.
busy  output  1  FSM not in IDLE.

Behaviour:
- One clock domain (clk); reset is asynchronous, active-low (rst_n). All state is registered on rising clk edge or cleared by rst_n low.
- Reset values: state=IDLE, accumulator=0, beat counter=0, out_ovf=0. Outputs in_ready=0, out_valid=0, out_acc=0, busy=0.
- Beat value = {in_cout, in_sum}, zero-extended to ACC_W bits.
- Accept = in_valid & in_ready. in_ready and out_valid are decoded from the registered state only, with no combinational path from in_valid or out_ready.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: clear accumulator, counter and ovf, then go to ACCUM.
  - in_valid is ignored while in IDLE.
- ACCUM:
  - in_ready=1.
  - On accept: acc <= acc + beat (wraps modulo 2^ACC_W). ovf <= ovf | carry-out of the ACC_W add. count <= count+1.
  - On accept with count==FRAME_LEN-1: go to HOLD. out_valid=1 in the next cycle, so latency is 1 cycle from the last beat.
  - Cycles without accept change nothing; gaps are unlimited.
  - start is ignored while in ACCUM.
- HOLD:
  - in_ready=0, out_valid=1. out_acc and out_ovf are held stable until handshake.
  - On out_ready=1 with start=0: go to IDLE. out_acc keeps its last value; out_ovf keeps its value until the next start.
  - On out_ready=1 with start=1 in the same cycle: clear acc, count and ovf, then go directly to ACCUM (back-to-back frames, no IDLE cycle).
  - start without out_ready in HOLD is ignored and not remembered.
- out_acc always reflects the accumulator register; it is meaningful only while out_valid=1.
- FRAME_LEN=1: a single accept moves ACCUM to HOLD.
- rst_n low at any point, including mid-frame or in HOLD: immediate return to reset values. Partial frame is discarded, and no out_valid is produced for it.
- busy = (state != IDLE).

Test Plan:
- Reset, then start, then 4 beats {cout,sum}=14,14,14,14 with in_valid held high and out_ready=1 (ACC_W=8, FRAME_LEN=4) -> out_valid high exactly 1 cycle after the 4th accept, out_acc=56 (0x38), out_ovf=0, then IDLE with busy=0.
- ACC_W=4, FRAME_LEN=4, beats 14,14,14,14 -> out_acc=8, out_ovf=1. Sequence: 14, 28 wraps to 12 with ovf set, 26 wraps to 10, 24 wraps to 8.
- Beats 1,2,3,4 with in_valid toggling 1-0-0-1-0-1-1 -> exactly 4 accepts counted, out_acc=10, no extra beats absorbed. in_ready=0 once HOLD is reached, even if in_valid stays high.
- Frame of 2,2,2,2 (total 8) with out_ready held low for 6 cycles in HOLD -> out_valid stays 1 and out_acc stays 8 throughout. Then out_ready=1 with start=1 -> next frame of 1,1,1,1 gives out_acc=4 with no IDLE cycle between frames.
- After 2 of 4 beats (acc=5), assert rst_n=0 asynchronously mid-cycle -> out_acc=0, in_ready=0, busy=0 immediately. After release, a new start plus 4 beats of 3 -> out_acc=12.
- start pulsed during ACCUM and in_valid pulsed during IDLE -> both ignored; the frame total is unchanged from the same-beat reference run.
